// File: rtl/plot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// plot_pkg
// Shared definitions for the VGA plot-port arbiter:
//   - default coordinate / colour widths (160x120 screen, 3-bit colour)
//   - requester index constants
//   - arbiter FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package plot_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    localparam int REQ_PLAYER  = 0;
    localparam int REQ_BIRD    = 1;
    localparam int REQ_OVERLAY = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/plot_arbiter_if.sv
// -----------------------------------------------------------------------------
// plot_arbiter_if
// Bundles the requester-side inputs and the VGA-side outputs of the arbiter.
//   master : drawing datapaths (drive req/plot_in/last_in and packed pixels,
//            observe gnt and the VGA write port)
//   slave  : the arbiter itself
// Packed buses: requester i uses bits [i*W +: W].
// -----------------------------------------------------------------------------
interface plot_arbiter_if #(
    parameter int NREQ = 3,
    parameter int X_W  = plot_pkg::X_W,
    parameter int Y_W  = plot_pkg::Y_W,
    parameter int C_W  = plot_pkg::C_W
);
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     plot_in;
    logic [NREQ-1:0]     last_in;
    logic [NREQ*X_W-1:0] x_in;
    logic [NREQ*Y_W-1:0] y_in;
    logic [NREQ*C_W-1:0] colour_in;

    logic [NREQ-1:0]     gnt;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [C_W-1:0]      colour;
    logic                plot;
    logic                busy;
    logic                timeout_err;

    modport master (
        output req, plot_in, last_in, x_in, y_in, colour_in,
        input  gnt, x, y, colour, plot, busy, timeout_err
    );

    modport slave (
        input  req, plot_in, last_in, x_in, y_in, colour_in,
        output gnt, x, y, colour, plot, busy, timeout_err
    );
endinterface

// File: rtl/plot_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin pick: returns the first requester with req high
// at or after rr_ptr, wrapping circularly.
//   req     in  NREQ   request vector
//   rr_ptr  in  IDX_W  search start index (always < NREQ)
//   sel     out IDX_W  chosen requester (0 when none)
//   any_req out 1      at least one request is high
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] sel,
    output logic             any_req
);
    import plot_pkg::*;

    int cand;

    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            // First hit in search order wins; later hits are ignored.
            if (!any_req && req[cand]) begin
                sel     = IDX_W'(cand);
                any_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/plot_arbiter.sv
// -----------------------------------------------------------------------------
// plot_arbiter
// Shares the single VGA adapter write port between NREQ pixel requesters
// (player crosshair, bird sprite, background/score overlay). Round-robin,
// one owner at a time, bursts terminated by last, and a stall timeout that
// revokes a grant after TIMEOUT cycles without an accepted pixel.
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   bus    slave modport of plot_arbiter_if:
//          req/plot_in/last_in/x_in/y_in/colour_in from requesters,
//          gnt (one-hot), x/y/colour/plot to the VGA adapter, busy,
//          timeout_err (one-cycle pulse on timeout revocation)
// All outputs are registered; an accepted pixel appears on the port one
// cycle after its plot_in.
// -----------------------------------------------------------------------------
module plot_arbiter #(
    parameter int NREQ    = 3,
    parameter int X_W     = plot_pkg::X_W,
    parameter int Y_W     = plot_pkg::Y_W,
    parameter int C_W     = plot_pkg::C_W,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          reset,
    plot_arbiter_if.slave bus
);
    import plot_pkg::*;

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    // Unpacked per-requester views of the packed pixel buses.
    logic [X_W-1:0] x_arr      [NREQ];
    logic [Y_W-1:0] y_arr      [NREQ];
    logic [C_W-1:0] colour_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi]      = bus.x_in[gi*X_W +: X_W];
            assign y_arr[gi]      = bus.y_in[gi*Y_W +: Y_W];
            assign colour_arr[gi] = bus.colour_in[gi*C_W +: C_W];
        end
    endgenerate

    state_t           state_reg;
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] owner_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic [X_W-1:0]   x_reg;
    logic [Y_W-1:0]   y_reg;
    logic [C_W-1:0]   colour_reg;
    logic             plot_reg;
    logic             busy_reg;
    logic             timeout_err_reg;

    logic [IDX_W-1:0] sel;
    logic             any_req;

    rr_select #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_reg),
        .sel     (sel),
        .any_req (any_req)
    );

    logic             granted;
    logic             own_req;
    logic             accept;
    logic             timeout_hit;
    logic             release_now;
    logic [IDX_W-1:0] ptr_next;

    assign granted     = (state_reg == ST_GRANT);
    assign own_req     = bus.req[owner_reg];
    assign accept      = granted & own_req & bus.plot_in[owner_reg];
    // An accepted pixel always beats the stall limit; a dropped req is never a timeout.
    assign timeout_hit = granted & own_req & ~accept & (cnt_reg == CNT_LAST);
    assign release_now = granted & (~own_req | (accept & bus.last_in[owner_reg]) | timeout_hit);
    assign ptr_next    = (owner_reg == IDX_LAST) ? '0 : owner_reg + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            rr_ptr_reg      <= '0;
            owner_reg       <= '0;
            cnt_reg         <= '0;
            gnt_reg         <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            colour_reg      <= '0;
            plot_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            plot_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        state_reg <= ST_GRANT;
                        owner_reg <= sel;
                        gnt_reg   <= NREQ'(1) << sel;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (accept) begin
                        plot_reg   <= 1'b1;
                        x_reg      <= x_arr[owner_reg];
                        y_reg      <= y_arr[owner_reg];
                        colour_reg <= colour_arr[owner_reg];
                    end
                    if (release_now) begin
                        state_reg       <= ST_IDLE;
                        gnt_reg         <= '0;
                        busy_reg        <= 1'b0;
                        rr_ptr_reg      <= ptr_next;
                        timeout_err_reg <= timeout_hit;
                    end else if (accept) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_reg;
    assign bus.x           = x_reg;
    assign bus.y           = y_reg;
    assign bus.colour      = colour_reg;
    assign bus.plot        = plot_reg;
    assign bus.busy        = busy_reg;
    assign bus.timeout_err = timeout_err_reg;
endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, colour, plot) between several pixel-drawing requesters: player crosshair, bird sprite, and background/score overlay.
- Each requester asks for the port with req, draws a burst of pixels while granted, and marks its final pixel with last.
- Arbitration is round-robin with one-grant-at-a-time ownership and a stall timeout.
- Sits between the movement/firing datapaths and the vga_adapter instance at top level.

Parameters:
- NREQ, 3, number of requesters (index 0 = player, 1 = bird, 2 = overlay).
- X_W, 8, x coordinate width (160-column screen).
- Y_W, 7, y coordinate width (120-row screen).
- C_W, 3, colour width.
- TIMEOUT, 256, cycles a grant may sit with no accepted plot before it is revoked.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held high for the whole burst.
- plot_in  in  NREQ  per-requester pixel-valid strobe.
- last_in  in  NREQ  marks the final pixel of a burst; qualified by plot_in.
- x_in  in  NREQ*X_W  packed x coordinates; requester i uses bits [i*X_W +: X_W].
- y_in  in  NREQ*Y_W  packed y coordinates, same packing.
- colour_in  in  NREQ*C_W  packed colours, same packing.
- gnt  out  NREQ  one-hot grant; all zero when the port is free.
- x  out  X_W  x coordinate to the VGA adapter.
- y  out  Y_W  y coordinate to the VGA adapter.
- colour  out  C_W  colour to the VGA adapter.
- plot  out  1  write enable to the VGA adapter.
- busy  out  1  high while any grant is active.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset: asynchronous. gnt, x, y, colour, plot, busy and timeout_err all go to 0. FSM goes to IDLE, rr_ptr to 0, stall counter to 0. Reset in mid-burst discards the burst; no further pixel is emitted.
- FSM states: IDLE and GRANT.
- IDLE:
  - With any req high, select the first requester at or after rr_ptr (circular search).
  - Next cycle: gnt[sel]=1, busy=1, state GRANT.
  - With no req high, stay in IDLE.
- GRANT:
  - Owner o is the requester with gnt[o]=1.
  - A pixel is accepted when gnt[o] & req[o] & plot_in[o] are all high in the same cycle.
  - An accepted pixel registers x/y/colour from slice o and drives plot=1 on the next cycle (latency 1).
  - Otherwise plot=0, and x/y/colour hold their last values.
  - plot_in from any non-owner is ignored, with no side effects.
- Release conditions, evaluated each GRANT cycle:
  - (a) accepted pixel with last_in[o]=1: that pixel is still emitted.
  - (b) req[o]=0: plot_in in that cycle is ignored.
  - (c) stall counter reaches TIMEOUT-1 with no accepted pixel this cycle.
- On release: next cycle gnt=0, busy=0, state IDLE, rr_ptr=(o+1) mod NREQ.
  - The minimum gap between grants is one IDLE cycle.
  - A requester that keeps req high is granted again only after others get their turn.
- Stall counter:
  - Cleared on entry to GRANT and on every accepted pixel.
  - Otherwise increments.
  - Width is clog2(TIMEOUT).
  - Under (c), timeout_err pulses high for exactly one cycle, aligned with gnt dropping.
- Simultaneous events:
  - last with req dropping in the same cycle: no pixel, because req is low. Release is treated as (b).
  - Accepted pixel in the same cycle the counter would hit its limit: the pixel wins, the counter clears, no timeout.
- Single requester: it is re-granted after each one-cycle IDLE gap.
- gnt is always one-hot or zero. It is a registered output and never combinational from req.

Decomposition:
- Shared package plot_pkg holds:
  - X_W, Y_W, C_W
  - requester index constants REQ_PLAYER=0, REQ_BIRD=1, REQ_OVERLAY=2
  - state encoding ST_IDLE / ST_GRANT
- One sub-module, rr_select: combinational round-robin pick from req and rr_ptr. Outputs sel index and any_req.

Test Plan:
- Reset, then req=3'b010; bird plots 4 pixels (x=10..13, y=20, colour=3'b100), last on the 4th → gnt=010 one cycle after req; four plot pulses, each one cycle after plot_in; gnt=0 after the last pixel; rr_ptr=2.
- All req=3'b111 held, each burst 2 pixels → grant order 0,1,2,0 with one IDLE cycle between grants.
- Bird granted; player asserts plot_in with x=99 → no output pixel with x=99; bird's pixels unaffected.
- TIMEOUT=16; player granted, never plots → gnt drops 16 cycles after the grant; timeout_err is a single one-cycle pulse; next requester is granted after the IDLE cycle.
- Owner drops req in mid-burst while asserting plot_in → that pixel is not emitted; gnt=0 next cycle.
- Overlay emits 3 pixels, reset asserted between pixel 2 and 3 → all outputs 0 immediately; pixel 3 is never plotted; after reset release, rr_ptr=0 and player wins a contended request.
